// File: rtl/serial_subtractor_pkg.sv
// Shared state encodings and sizing helper for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, start/busy/done handshake.
import serial_subtractor_pkg::*;

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_bin;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_shift;

    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last  = (r_state == S_RUN) && (r_cnt == LAST);
    assign w_shift = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake flags are registered copies of the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_RUN) || (w_next == S_DONE);
            r_done <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
            r_bin <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_res <= w_shift;
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_bin <= w_bout;
            r_cnt <= r_cnt + CW'(1);
            // On the last bit the operand LSBs hold the captured MSBs.
            if (w_last) begin
                r_diff   <= w_shift;
                r_borrow <= w_bout;
                r_ovf    <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;

endmodule
